// File: rtl/vga_rect_fill.sv
`default_nettype none
// ============================================================================
// Module      : vga_rect_fill
// Description : Memory-mapped rectangle-fill controller for the vga_adapter.
//               Software loads origin (XY), size (SIZE) and colour (COLOUR),
//               then writes a start command to CTRL. The block then presents
//               one pixel per clock in raster order, pulsing vga_plot for
//               each on-screen pixel.
// Ports       : clk, resetn (async active-low)
//               cs, W, addr[1:0], wdata[31:0] - bus write side
//               rdata[31:0]                   - combinational register read
//               vga_x, vga_y, vga_colour, vga_plot - pixel stream to adapter
//               busy                          - fill in progress
// Revision    : 1.0 - initial release
// ============================================================================
module vga_rect_fill #(
    parameter int H_RES    = 800,
    parameter int V_RES    = 600,
    parameter int COLOUR_W = 9
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cs,
    input  logic                W,
    input  logic [1:0]          addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [15:0]         vga_x,
    output logic [15:0]         vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [16:0] C_H_LIM = 17'(H_RES);
    localparam logic [16:0] C_V_LIM = 17'(V_RES);

    state_t                state_q, state_d;
    logic [15:0]           x0_q, x0_d;
    logic [15:0]           y0_q, y0_d;
    logic [15:0]           w_q, w_d;
    logic [15:0]           h_q, h_d;
    logic [COLOUR_W-1:0]   col_q, col_d;
    // Pixel cursor is one bit wider than the bus coordinate so a rectangle
    // extending past 65535 never wraps back on-screen or misses its end.
    logic [16:0]           cx_q, cx_d;
    logic [16:0]           cy_q, cy_d;
    logic                  done_q, done_d;

    logic                  w_wr;
    logic [16:0]           w_x_end;
    logic [16:0]           w_y_end;
    logic                  w_row_end;
    logic                  w_last;

    assign w_wr      = cs & W;
    assign w_x_end   = {1'b0, x0_q} + {1'b0, w_q} - 17'd1;
    assign w_y_end   = {1'b0, y0_q} + {1'b0, h_q} - 17'd1;
    assign w_row_end = (cx_q == w_x_end);
    assign w_last    = w_row_end && (cy_q == w_y_end);

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        col_d   = col_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        done_d  = done_q;

        case (state_q)
            S_IDLE: begin
                // Abort (bit2) has no meaning in IDLE and is simply dropped.
                if (w_wr) begin
                    case (addr)
                        2'd0: begin
                            x0_d = wdata[15:0];
                            y0_d = wdata[31:16];
                        end
                        2'd1: begin
                            w_d = wdata[15:0];
                            h_d = wdata[31:16];
                        end
                        2'd2: col_d = wdata[COLOUR_W-1:0];
                        default: begin
                            if (wdata[1]) begin
                                done_d = 1'b0;
                            end
                            // Start is evaluated after clear so it decides
                            // the final done value.
                            if (wdata[0]) begin
                                if ((w_q != 16'd0) && (h_q != 16'd0)) begin
                                    state_d = S_RUN;
                                    cx_d    = {1'b0, x0_q};
                                    cy_d    = {1'b0, y0_q};
                                    done_d  = 1'b0;
                                end else begin
                                    done_d  = 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
            default: begin
                // Cursor holds on abort and on completion so vga_x/vga_y keep
                // the last presented pixel while idle.
                if (w_wr && (addr == 2'd3) && wdata[2]) begin
                    state_d = S_IDLE;
                end else if (w_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (w_row_end) begin
                    cx_d = {1'b0, x0_q};
                    cy_d = cy_q + 17'd1;
                end else begin
                    cx_d = cx_q + 17'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            col_q   <= col_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0:    rdata = {y0_q, x0_q};
            2'd1:    rdata = {h_q, w_q};
            2'd2:    rdata = {{(32-COLOUR_W){1'b0}}, col_q};
            default: rdata = {30'd0, done_q, (state_q == S_RUN)};
        endcase
    end

    assign busy       = (state_q == S_RUN);
    assign vga_x      = cx_q[15:0];
    assign vga_y      = cy_q[15:0];
    assign vga_colour = col_q;
    assign vga_plot   = busy && (cx_q < C_H_LIM) && (cy_q < C_V_LIM);

endmodule
`default_nettype wire
